// File: rtl/fetch_buff_ctrl.sv
// fetch_buff_ctrl: queues instruction-fetch requests in a 4-entry FIFO and
//    serialises them onto a single-outstanding instruction-memory read port.
// Latency: request in N -> buff_ack in N+1 -> mem_rd_en in N+2 (unloaded);
//    mem_ack in M -> buff2wave_valid in M+1.
// Backpressure: buff_ack withheld while the FIFO holds 4 entries; mem_rd_en held until mem_ack.
//
// Ports:
//    clk, rst                   single clock, synchronous active-high reset
//    buff_rd_en/addr/tag        fetch request, held by fetch until buff_ack pulses
//    buff_ack                   one-cycle capture acknowledge
//    buff_addr_err              misaligned request flag (only with FETCH_BUFF_ALIGN_CHECK_EN)
//    mem_rd_en/addr, mem_ack    instruction-memory read handshake, mem_rd_data valid with mem_ack
//    buff2wave_valid/instr/tag  one-cycle response pulse; instr/tag hold until the next response
//
// Optional feature: define FETCH_BUFF_ALIGN_CHECK_EN to ack-and-drop requests
// whose address is not 4-byte aligned and flag them on buff_addr_err. Without it,
// the low two address bits are stored but forced to zero on mem_addr.

module fetch_buff_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        buff_rd_en,
   input  logic [31:0] buff_addr,
   input  logic [38:0] buff_tag,
   output logic        buff_ack,
`ifdef FETCH_BUFF_ALIGN_CHECK_EN
   output logic        buff_addr_err,
`endif
   output logic        mem_rd_en,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [63:0] mem_rd_data,
   output logic        buff2wave_valid,
   output logic [63:0] buff2wave_instr,
   output logic [38:0] buff2wave_tag
);

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_MEM = 1'b1
   } state_t;

   state_t      state, next_state;

   logic [31:0] fifo_addr [4];
   logic [38:0] fifo_tag  [4];
   logic [1:0]  wr_ptr;
   logic [1:0]  rd_ptr;
   logic [2:0]  count;

   logic        capture;
   logic        push;
   logic        pop;
   logic        rsp;
   logic [38:0] cur_tag;

   // Capture looks only at the current count: a pop in the same cycle does
   // not open a slot for a request arriving while the FIFO is full. The
   // buff_ack term blocks a second capture of the request fetch is still
   // holding during its ack cycle.
   assign capture = buff_rd_en && !buff_ack && (count != 3'd4);

`ifdef FETCH_BUFF_ALIGN_CHECK_EN
   logic misaligned;
   assign misaligned = (buff_addr[1:0] != 2'b00);
   // Misaligned requests are acknowledged but never enter the FIFO.
   assign push = capture && !misaligned;
`else
   assign push = capture;
`endif

   // Memory FSM: state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Memory FSM: next state and pop/response strobes
   always_comb begin
      next_state = state;
      pop        = 1'b0;
      rsp        = 1'b0;
      case (state)
         IDLE: begin
            // mem_ack seen here is stale (e.g. after a reset) and is ignored.
            if (count != 3'd0) begin
               pop        = 1'b1;
               next_state = WAIT_MEM;
            end
         end
         WAIT_MEM: begin
            if (mem_ack) begin
               rsp        = 1'b1;
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // FIFO storage; contents are don't-care while a slot is empty, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= buff_addr;
         fifo_tag[wr_ptr]  <= buff_tag;
      end
   end

   // FIFO pointers wrap naturally at 2 bits; count spans 0..4.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 3'd0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 2'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 2'd1;
         end
         case ({push, pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end

   // Request acknowledge (and misalignment flag) registered off the capture decision.
   always_ff @(posedge clk) begin
      if (rst) begin
         buff_ack <= 1'b0;
`ifdef FETCH_BUFF_ALIGN_CHECK_EN
         buff_addr_err <= 1'b0;
`endif
      end else begin
         buff_ack <= capture;
`ifdef FETCH_BUFF_ALIGN_CHECK_EN
         buff_addr_err <= capture && misaligned;
`endif
      end
   end

   // Memory read port and wave response. The popped tag is parked in cur_tag
   // for the duration of the read so the FIFO slot can be reused immediately.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_rd_en       <= 1'b0;
         mem_addr        <= 32'd0;
         cur_tag         <= 39'd0;
         buff2wave_valid <= 1'b0;
         buff2wave_instr <= 64'd0;
         buff2wave_tag   <= 39'd0;
      end else begin
         if (pop) begin
            mem_rd_en <= 1'b1;
            mem_addr  <= fifo_addr[rd_ptr] & 32'hFFFF_FFFC;
            cur_tag   <= fifo_tag[rd_ptr];
         end else if (rsp) begin
            mem_rd_en <= 1'b0;
         end
         buff2wave_valid <= rsp;
         if (rsp) begin
            buff2wave_instr <= mem_rd_data;
            buff2wave_tag   <= cur_tag;
         end
      end
   end

endmodule
